// File: rtl/audio_mixer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : audio_mixer
// Description : Multi-voice audio mixer feeding the audio codec write port.
//               Each sample is built serially, one channel per cycle:
//               acc += en ? (data * vol) >>> VOL_BITS : 0, then clamped to
//               the signed WIDTH range and loaded into the output register.
//               The codec always receives the sample mixed after the previous
//               handshake (one-sample latency; first sample after reset is 0).
//
//               Optional feature macro: AUDIO_MIXER_PAN_EN
//                 defined   -> ch_pan input, independent left/right
//                              accumulators and clamps, clip = OR of both
//                 undefined -> mono, writedata_right mirrors writedata_left
//
// Ports       : clk             system clock
//               reset_n         asynchronous active-low reset
//               ch_data         CHANNELS signed samples, channel i at [i*WIDTH +: WIDTH]
//               ch_vol          CHANNELS unsigned volumes, VOL_BITS each
//               ch_en           channel enable mask
//               ch_pan          (pan build only) 2 bits/channel:
//                               00 both, 01 left only, 10 right only, 11 muted
//               read_ready      codec ready (read side)
//               write_ready     codec ready (write side)
//               read / write    codec strobes, asserted only in IDLE
//               writedata_left  left sample
//               writedata_right right sample
//               busy            a mix is in progress
//               clip            last completed sample saturated
//
// Revision    : 1.0 - initial release
// ============================================================================
module audio_mixer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 24,
    parameter int VOL_BITS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS*WIDTH-1:0]    ch_data,
    input  logic [CHANNELS*VOL_BITS-1:0] ch_vol,
    input  logic [CHANNELS-1:0]          ch_en,
`ifdef AUDIO_MIXER_PAN_EN
    input  logic [2*CHANNELS-1:0]        ch_pan,
`endif
    input  logic                         read_ready,
    input  logic                         write_ready,
    output logic                         read,
    output logic                         write,
    output logic [WIDTH-1:0]             writedata_left,
    output logic [WIDTH-1:0]             writedata_right,
    output logic                         busy,
    output logic                         clip
);

    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = WIDTH + VOL_BITS + 1;
    // Sized so that CHANNELS full-scale terms can never overflow.
    localparam int ACC_W  = WIDTH + VOL_BITS + $clog2(CHANNELS) + 1;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] c_sat_max =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Snapshot of the inputs taken at the handshake.
    logic [CHANNELS*WIDTH-1:0]    r_data;
    logic [CHANNELS*VOL_BITS-1:0] r_vol;
    logic [CHANNELS-1:0]          r_en;
    logic [IDX_W-1:0]             r_idx;
    logic signed [ACC_W-1:0]      r_acc_l;
    logic [WIDTH-1:0]             r_out_l;
    logic                         r_clip;

    logic                         w_hs;
    logic [WIDTH-1:0]             w_sel_data;
    logic [VOL_BITS-1:0]          w_sel_vol;
    logic                         w_sel_en;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_term;
    logic                         w_add_l;
    logic [WIDTH:0]               w_sat_l;

    // Clamp to the signed WIDTH range; MSB of the result flags saturation.
    function automatic logic [WIDTH:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > c_sat_max) begin
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        end else if (a < c_sat_min) begin
            return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, a[WIDTH-1:0]};
        end
    endfunction

    // ------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------
    assign w_hs  = (r_state == ST_IDLE) && read_ready && write_ready;
    assign read  = w_hs;
    assign write = w_hs;
    assign busy  = (r_state != ST_IDLE);
    assign clip  = r_clip;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_hs) w_state_next = ST_ACCUM;
            ST_ACCUM: if (r_idx == c_last_idx) w_state_next = ST_SAT;
            ST_SAT:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Channel selection and volume scaling
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_data = '0;
        w_sel_vol  = '0;
        w_sel_en   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_data = r_data[i*WIDTH +: WIDTH];
                w_sel_vol  = r_vol[i*VOL_BITS +: VOL_BITS];
                w_sel_en   = r_en[i];
            end
        end
    end

    // Volume is unsigned: zero-extend it before the signed multiply.
    assign w_prod = PROD_W'($signed(w_sel_data)) * PROD_W'($signed({1'b0, w_sel_vol}));
    // Arithmetic shift floors toward minus infinity.
    assign w_term = w_sel_en ? ACC_W'(w_prod >>> VOL_BITS) : '0;
    assign w_sat_l = saturate(r_acc_l);

`ifdef AUDIO_MIXER_PAN_EN
    logic [2*CHANNELS-1:0]   r_pan;
    logic signed [ACC_W-1:0] r_acc_r;
    logic [WIDTH-1:0]        r_out_r;
    logic [1:0]              w_sel_pan;
    logic                    w_add_r;
    logic [WIDTH:0]          w_sat_r;

    always_comb begin
        w_sel_pan = 2'b00;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_pan = r_pan[2*i +: 2];
            end
        end
    end

    // pan[1] excludes the left side, pan[0] excludes the right side.
    assign w_add_l = ~w_sel_pan[1];
    assign w_add_r = ~w_sel_pan[0];
    assign w_sat_r = saturate(r_acc_r);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pan   <= '0;
            r_acc_r <= '0;
            r_out_r <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_pan   <= ch_pan;
                        r_acc_r <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (w_add_r) r_acc_r <= r_acc_r + w_term;
                end
                ST_SAT: begin
                    r_out_r <= w_sat_r[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign writedata_right = r_out_r;
`else
    assign w_add_l         = 1'b1;
    assign writedata_right = r_out_l;
`endif

    assign writedata_left = r_out_l;

    // ------------------------------------------------------------------
    // Mix datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_vol   <= '0;
            r_en    <= '0;
            r_idx   <= '0;
            r_acc_l <= '0;
            r_out_l <= '0;
            r_clip  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_data  <= ch_data;
                        r_vol   <= ch_vol;
                        r_en    <= ch_en;
                        r_idx   <= '0;
                        r_acc_l <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (w_add_l) r_acc_l <= r_acc_l + w_term;
                    if (r_idx != c_last_idx) r_idx <= r_idx + 1'b1;
                end
                ST_SAT: begin
                    r_out_l <= w_sat_l[WIDTH-1:0];
`ifdef AUDIO_MIXER_PAN_EN
                    r_clip  <= w_sat_l[WIDTH] | w_sat_r[WIDTH];
`else
                    r_clip  <= w_sat_l[WIDTH];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/audio_mixer.md
# audio_mixer

Parametrised multi-voice audio mixer between the game's sound sources (music, shot, explosion, UFO voices) and the audio codec write port. It replaces the direct single-source mono wiring with a per-channel volume stage, enable mask, saturating sum and an owned codec handshake. It computes each sample serially, one channel per cycle, into a pre-loaded output register, so a sample is always ready when the codec asks.

## Interface
- `CHANNELS`, default 4: number of input voices (≥1).
- `WIDTH`, default 24: signed sample width, in and out.
- `VOL_BITS`, default 4: unsigned per-channel volume width.
- `clk` input, 1 bit: system clock (CLOCK_50 domain).
- `reset_n` input, 1 bit: one clock; reset is asynchronous and active-low.
- `ch_data` input, CHANNELS*WIDTH bits: signed samples; channel i is at `[i*WIDTH +: WIDTH]`.
- `ch_vol` input, CHANNELS*VOL_BITS bits: volume per channel.
- `ch_en` input, CHANNELS bits: channel enable mask.
- `read_ready` input, 1 bit: codec ready.
- `write_ready` input, 1 bit: codec ready.
- `read` output, 1 bit: codec read strobe.
- `write` output, 1 bit: codec write strobe.
- `writedata_left` output, WIDTH bits: left sample, signed.
- `writedata_right` output, WIDTH bits: right sample, signed.
- `busy` output, 1 bit: a mix is in progress.
- `clip` output, 1 bit: the last completed sample saturated.

## Operation
- FSM states: IDLE, ACCUM, SAT.
- **IDLE**
  - `read = write = read_ready & write_ready`. The strobes are combinational from registered state and are asserted only in IDLE.
  - On a handshake: snapshot `ch_data`, `ch_vol` and `ch_en`, clear the accumulator, set index to 0, go to ACCUM.
- **ACCUM**, one channel per cycle
  - Each cycle: `acc += en ? (data * vol) >>> VOL_BITS : 0`. The shift is arithmetic, so it floors toward −∞.
  - After channel CHANNELS−1, go to SAT.
- **SAT**
  - Clamp `acc` to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Load the clamped value into both output registers.
  - `clip` = 1 if the clamp changed the value, else 0.
  - Go to IDLE.
- Accumulator width is WIDTH + VOL_BITS + clog2(CHANNELS) + 1, so there is no internal overflow.
- `busy` = 1 when the state is ACCUM or SAT.
- Readiness asserted while busy is not consumed. The strobes fire on the first IDLE cycle in which both readies are high.
- Input changes after the snapshot do not affect the sample in progress.
- The output always carries the sample computed after the previous handshake, giving one-sample pipeline latency. The first handshake after reset sends 0.
- Reset values, asynchronous: state IDLE, outputs 0, `busy` 0, `clip` 0, accumulator 0.
- Reset asserted mid-mix aborts the mix, and the outputs return to 0 immediately.

## Timing
- Handshake in cycle N: `read`/`write` are high in cycle N only.
- Channel i accumulates in cycle N+1+i.
- SAT runs in cycle N+CHANNELS+1. Outputs and `clip` are valid from cycle N+CHANNELS+2, which is also when the state is back in IDLE.
- `busy` is high from cycle N+1 through N+CHANNELS+1.
- Minimum handshake spacing is CHANNELS+2 cycles. At 48 kHz this is always satisfied.
- A mix is never retriggered without a new handshake.

## Configuration
- `AUDIO_MIXER_PAN_EN`
  - Defined: adds input `ch_pan [2*CHANNELS-1:0]`. Per channel: 00 = both sides, 01 = left only, 10 = right only, 11 = muted.
  - Defined: uses two accumulators, each clamped independently. `clip` is the OR of both clamps.
  - Undefined: no `ch_pan` port and a single accumulator. `writedata_right` equals `writedata_left` (mono).

## Test plan
1. **Reset output.** Hold `reset_n`=0, then release. Expected: outputs 0, `read`/`write`/`busy`/`clip` 0. Raise both readies: one-cycle strobe, data 0.
2. **Single channel.** Ch0 = 0x100000, vol 8, en 0001; handshake; then a second handshake. Expected: second handshake presents 0x080000 on both sides; `busy` high for 5 cycles; `clip` 0.
3. **Positive saturation.** All 4 channels = 0x7FFFFF, vol 15, en 1111. Expected: output 0x7FFFFF, `clip` 1. A following mix of all channels at 0 gives output 0 and `clip` 0.
4. **Negative saturation.** Ch0 and ch1 = 0x800000, vol 15, others disabled. Expected: output 0x800000, `clip` 1. Disabled channels holding nonzero data have no effect.
5. **Readiness during busy.** Readies held high continuously. Expected: strobes exactly every CHANNELS+2 = 6 cycles, never during `busy`. Assert `reset_n` low mid-ACCUM: immediate IDLE with zero outputs.
6. **Pan (`AUDIO_MIXER_PAN_EN` defined).** Ch0 = 0x100000, vol 8, pan 01; ch1 = 0x200000, vol 8, pan 10. Expected: left 0x080000, right 0x100000.
